farm_prefetch: RTL and testbench
================================

FARM_PREFETCH -- requirements
Module: farm_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_req  output  1  fetch request to program memory interface.
REQ-006 mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
REQ-007 mem_gnt  input  1  request accepted this cycle when mem_req&mem_gnt.
REQ-008 mem_rvalid  input  1  read data returned, at least one cycle after grant.
REQ-009 mem_rdata  input  32  instruction word, valid with mem_rvalid.
REQ-010 redirect  input  1  branch/jump from execute: flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-012 if_valid  output  1  queue head holds a valid instruction for decode.
REQ-013 if_instr  output  32  instruction at queue head.
REQ-014 if_pc  output  32  address of if_instr.
REQ-015 if_ready  input  1  decode consumes head when if_valid&if_ready.

Function
REQ-016 The block SHALL hold a fetch pointer fpc, at most one outstanding memory transaction, and a DEPTH-entry FIFO of {pc, instr}.
REQ-017 FSM states SHALL be IDLE (no request), REQ (mem_req=1 awaiting gnt), WAIT (granted, awaiting rvalid).
REQ-018 IDLE->REQ SHALL occur when count+0 < DEPTH (free slot reserved for the response); otherwise stay IDLE.
REQ-019 REQ->WAIT on mem_gnt, latching fpc as the in-flight pc and advancing fpc by 4 (32-bit wrap 32'hFFFF_FFFC->0).
REQ-020 mem_addr SHALL equal fpc and remain stable while in REQ unless redirect occurs.
REQ-021 WAIT on mem_rvalid SHALL push {in-flight pc, mem_rdata} and go to REQ if a slot remains after the push (counting a same-cycle pop), else IDLE.
REQ-022 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-023 Pop on empty or push on full SHALL never occur; slot reservation guarantees a response always has space.
REQ-024 if_valid SHALL be count!=0; if_instr/if_pc SHALL be the head entry with zero combinational path from mem_rdata (minimum one-cycle fetch-to-decode latency).
REQ-025 redirect SHALL, in the same edge, empty the FIFO (if_valid=0 next cycle), discard any pop, and load fpc with {redirect_pc[31:2],2'b00}.
REQ-026 redirect in IDLE or REQ SHALL go to REQ with mem_addr=new fpc next cycle; a grant coinciding with redirect SHALL be treated as a request to be discarded.
REQ-027 redirect in WAIT (or with a coinciding grant) SHALL set a drop flag; the next mem_rvalid SHALL be discarded, flag cleared, then go to REQ.
REQ-028 redirect coinciding with mem_rvalid in WAIT SHALL discard that response and go to REQ.
REQ-029 Back-to-back fetches SHALL sustain one instruction per cycle when memory grants and returns each cycle? No: one outstanding only, so throughput SHALL be one instruction per (grant+return) latency, minimum 2 cycles.

Reset
REQ-030 During rst: mem_req=0, if_valid=0, count=0, drop flag=0, state IDLE, fpc=RESET_PC, FIFO pointers 0.
REQ-031 First mem_req SHALL assert on the first clock edge after rst deasserts, with mem_addr=RESET_PC.
REQ-032 rst mid-transaction SHALL abandon it; a stale mem_rvalid arriving after reset release while in IDLE/REQ SHALL be ignored.

Structure
REQ-033 farm_pkg SHALL hold typedef fetch_state_t {IDLE, REQ, WAIT}, typedef if_entry_t {pc, instr}, and constant RESET_PC_DEF.
REQ-034 The FIFO SHALL be a sub-module farm_ifq (parameterised DEPTH, push/pop/flush, count) instantiated once.

Verification
REQ-035 Reset release, memory gnt same cycle, rvalid next cycle, if_ready=1 -> mem_addr 0,4,8,... and if_pc 0,4,8 with matching instr from program hex.
REQ-036 if_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries queued, mem_req stays 0 after 4th grant, no data lost on release.
REQ-037 redirect to 32'h0000_0103 while in WAIT, rvalid returns 2 cycles later -> that word dropped, next mem_addr 32'h0000_0100, first if_pc 32'h100.
REQ-038 Simultaneous push and pop with FIFO full-1 -> count unchanged, order preserved.
REQ-039 rst asserted while in WAIT, rvalid arrives after release -> ignored, first if_pc equals RESET_PC.
REQ-040 fpc at 32'hFFFF_FFFC fetched -> next mem_addr 32'h0000_0000.

Source files
------------

// File: rtl/farm_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Pure declarations: no latency, no flow control.
package farm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/farm_prefetch_if.sv
// Prefetch bundle: program-memory request/response, redirect from execute, decode handoff.
// Wires only; master is the prefetch unit, slave is the memory/core environment.
interface farm_prefetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (
    output mem_req, mem_addr, if_valid, if_instr, if_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  mem_req, mem_addr, if_valid, if_instr, if_pc,
    output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, if_ready
  );

endinterface

// File: rtl/farm_ifq.sv
// Instruction queue: DEPTH-entry {pc, instr} FIFO with flush; head is registered, 1-cycle push-to-head.
// No internal backpressure: the caller reserves a slot before every push and only pops when non-empty.
module farm_ifq
  import farm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  if_entry_t     wr_dat,
  output if_entry_t     rd_dat,
  output logic [CW-1:0] count
);

  if_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/farm_prefetch.sv
// Instruction prefetch: one outstanding fetch into farm_ifq, >=2 cycles per fetch, >=1 cycle to decode.
// Requests only while a queue slot is free; redirect flushes and drops any in-flight response.
module farm_prefetch
  import farm_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  farm_prefetch_if.master  bus
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

  fetch_state_t  state, state_nxt;
  logic [31:0]   fpc, fpc_nxt;
  logic [31:0]   infl_pc, infl_pc_nxt;
  logic          drop, drop_nxt;
  logic          push, pop, granted, rsp;
  logic [CW-1:0] count;
  if_entry_t     head, wr_dat;

  assign pop     = bus.if_valid & bus.if_ready & ~bus.redirect;
  assign granted = (state == REQ) & bus.mem_gnt;
  assign rsp     = (state == WAIT) & bus.mem_rvalid;
  assign push    = rsp & ~drop & ~bus.redirect;

  always_comb begin
    state_nxt   = state;
    fpc_nxt     = fpc;
    infl_pc_nxt = infl_pc;
    drop_nxt    = drop;
    case (state)
      IDLE: if (bus.redirect || count < DEPTH_C) state_nxt = REQ;
      REQ: begin
        if (granted) begin
          infl_pc_nxt = fpc;
          fpc_nxt     = fpc + 32'd4;
          state_nxt   = WAIT;
          // The granted fetch is now stale; its response must be swallowed.
          if (bus.redirect) drop_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (rsp) begin
          drop_nxt = 1'b0;
          if (drop || bus.redirect)          state_nxt = REQ;
          else if (pop || count < DEPTH_M1) state_nxt = REQ;
          else                               state_nxt = IDLE;
        end else if (bus.redirect) begin
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.redirect) fpc_nxt = word_align(bus.redirect_pc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fpc     <= RESET_PC;
      infl_pc <= '0;
      drop    <= 1'b0;
    end else begin
      state   <= state_nxt;
      fpc     <= fpc_nxt;
      infl_pc <= infl_pc_nxt;
      drop    <= drop_nxt;
    end
  end

  assign wr_dat.pc    = infl_pc;
  assign wr_dat.instr = bus.mem_rdata;

  farm_ifq #(.DEPTH(DEPTH)) u_ifq (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (bus.redirect),
    .wr_dat (wr_dat),
    .rd_dat (head),
    .count  (count)
  );

  assign bus.mem_req  = (state == REQ);
  assign bus.mem_addr = fpc;
  assign bus.if_valid = (count != '0);
  assign bus.if_instr = head.instr;
  assign bus.if_pc    = head.pc;

endmodule

// File: tb/tb_farm_prefetch.sv
// Directed bench for farm_prefetch with a simple grant/response memory model and decode monitor.
module tb_farm_prefetch;
  import farm_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  farm_prefetch_if bus ();

  farm_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        gnt_en;
  int          rsp_delay;
  int          pend;
  logic [31:0] paddr;
  logic        req_s, gnt_s, g_l;
  logic [31:0] addr_s, a_l;
  int          cyc = 0;
  logic [31:0] gnt_q[$];
  if_entry_t   pop_q[$];
  int          pop_cyc[$];
  if_entry_t   mon_e;

  assign bus.mem_gnt = bus.mem_req & gnt_en;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Monitor: grants and decode handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    req_s  = bus.mem_req;
    gnt_s  = bus.mem_gnt;
    addr_s = bus.mem_addr;
    if (bus.mem_req && bus.mem_gnt) gnt_q.push_back(bus.mem_addr);
    if (bus.if_valid && bus.if_ready && !bus.redirect && !rst) begin
      mon_e.pc    = bus.if_pc;
      mon_e.instr = bus.if_instr;
      pop_q.push_back(mon_e);
      pop_cyc.push_back(cyc);
    end
  end

  // Memory model: response rsp_delay cycles after the grant cycle.
  always @(posedge clk) begin
    g_l = req_s & gnt_s;
    a_l = addr_s;
    #1;
    bus.mem_rvalid = 1'b0;
    if (g_l) begin
      pend  = rsp_delay;
      paddr = a_l;
    end
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = word(paddr);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; gnt_en = 1'b0; bus.if_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gnt_q.delete(); pop_q.delete(); pop_cyc.delete();
  endtask

  task automatic wait_pops(input int n, input string name);
    int t = 0;
    while (pop_q.size() < n && t < 200) begin @(posedge clk); t++; end
    #1;
    checks++;
    if (pop_q.size() < n) begin
      errors++;
      $display("FAIL %s pop timeout: got %0d pops, want %0d", name, pop_q.size(), n);
    end
  endtask

  task automatic wait_gnts(input int n, input string name);
    int t = 0;
    while (gnt_q.size() < n && t < 200) begin @(posedge clk); t++; end
    #1;
    checks++;
    if (gnt_q.size() < n) begin
      errors++;
      $display("FAIL %s grant timeout: got %0d grants, want %0d", name, gnt_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt_en = 1'b0; bus.if_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.if_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL release_req: got %b want 0", bus.mem_req); end
    @(posedge clk); #1;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== RPC) begin errors++; $display("FAIL first_addr: got %h want %h", bus.mem_addr, RPC); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    rsp_delay = 1; gnt_en = 1'b1; bus.if_ready = 1'b1;
    wait_pops(4, "stream");
    for (int i = 0; i < 4; i++) begin
      e = 32'(4 * i);
      checks++; if (pop_q[i].pc !== e) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pop_q[i].pc, e); end
      checks++; if (pop_q[i].instr !== word(e)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, pop_q[i].instr, word(e)); end
      checks++; if (gnt_q[i] !== e) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, gnt_q[i], e); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pop_cyc[i+1] - pop_cyc[i] != 2) begin
        errors++; $display("FAIL stream_rate[%0d]: got %0d cycles want 2", i, pop_cyc[i+1] - pop_cyc[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    rsp_delay = 1; gnt_en = 1'b1; bus.if_ready = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks++; if (gnt_q.size() != 4) begin errors++; $display("FAIL bp_grants: got %0d want 4", gnt_q.size()); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_idle: got %b want 0", bus.mem_req); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got %h want 0", bus.if_pc); end
    bus.if_ready = 1'b1;
    wait_pops(6, "bp");
    for (int i = 0; i < 6; i++) begin
      e = 32'(4 * i);
      checks++; if (pop_q[i].pc !== e) begin errors++; $display("FAIL bp_pc[%0d]: got %h want %h", i, pop_q[i].pc, e); end
      checks++; if (pop_q[i].instr !== word(e)) begin errors++; $display("FAIL bp_instr[%0d]: got %h want %h", i, pop_q[i].instr, word(e)); end
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] e;
    do_reset();
    rsp_delay = 1; gnt_en = 1'b1; bus.if_ready = 1'b0;
    wait_gnts(4, "pp");
    bus.if_ready = 1'b1;
    @(posedge clk); #1;
    bus.if_ready = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL pp_refetch: got %b want 1", bus.mem_req); end
    checks++; if (bus.if_pc !== 32'h4) begin errors++; $display("FAIL pp_head: got %h want 4", bus.if_pc); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (gnt_q.size() != 5) begin errors++; $display("FAIL pp_grants: got %0d want 5", gnt_q.size()); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL pp_full: got %b want 0", bus.mem_req); end
    bus.if_ready = 1'b1;
    wait_pops(5, "pp");
    for (int i = 0; i < 5; i++) begin
      e = 32'(4 * i);
      checks++; if (pop_q[i].pc !== e) begin errors++; $display("FAIL pp_pc[%0d]: got %h want %h", i, pop_q[i].pc, e); end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    rsp_delay = 2; gnt_en = 1'b1; bus.if_ready = 1'b1;
    wait_gnts(1, "redir");
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL redir_wait: got %b want 0", bus.mem_req); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", bus.if_valid); end
    wait_pops(2, "redir");
    checks++; if (gnt_q[1] !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want 00000100", gnt_q[1]); end
    checks++; if (pop_q[0].pc !== 32'h100) begin errors++; $display("FAIL redir_pc0: got %h want 00000100", pop_q[0].pc); end
    checks++; if (pop_q[0].instr !== word(32'h100)) begin errors++; $display("FAIL redir_instr0: got %h want %h", pop_q[0].instr, word(32'h100)); end
    checks++; if (pop_q[1].pc !== 32'h104) begin errors++; $display("FAIL redir_pc1: got %h want 00000104", pop_q[1].pc); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    rsp_delay = 3; gnt_en = 1'b1; bus.if_ready = 1'b1;
    wait_gnts(1, "rstw");
    rst = 1'b1; gnt_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    gnt_q.delete(); pop_q.delete(); pop_cyc.delete();
    @(posedge clk); #1;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstw_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== RPC) begin errors++; $display("FAIL rstw_addr: got %h want %h", bus.mem_addr, RPC); end
    @(posedge clk); #1;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rstw_stale: got %b want 0", bus.if_valid); end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstw_hold: got %b want 1", bus.mem_req); end
    rsp_delay = 1; gnt_en = 1'b1;
    wait_pops(1, "rstw");
    checks++; if (pop_q[0].pc !== RPC) begin errors++; $display("FAIL rstw_pc: got %h want %h", pop_q[0].pc, RPC); end
    checks++; if (pop_q[0].instr !== word(RPC)) begin errors++; $display("FAIL rstw_instr: got %h want %h", pop_q[0].instr, word(RPC)); end
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_delay = 1; gnt_en = 1'b0; bus.if_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h want fffffffc", bus.mem_addr); end
    gnt_en = 1'b1;
    wait_pops(2, "wrap");
    checks++; if (gnt_q[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", gnt_q[0]); end
    checks++; if (gnt_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 00000000", gnt_q[1]); end
    checks++; if (pop_q[0].instr !== word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr0: got %h want %h", pop_q[0].instr, word(32'hFFFF_FFFC)); end
    checks++; if (pop_q[1].pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h want 00000000", pop_q[1].pc); end
  endtask

  initial begin
    pend = 0; rsp_delay = 1; gnt_en = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    req_s = 1'b0; gnt_s = 1'b0; addr_s = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_push_pop_full();
    test_redirect_wait();
    test_reset_in_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
